// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the memory stage.
//   - wbsel encodings (WB_MEM / WB_ALU / WB_PC4)
//   - funct3 load/store size codes
//   - memory-stage FSM state enum
package riscv_pkg;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational byte-lane logic for the memory stage.
//   Store side: byte strobes and lane-replicated write data.
//   Load side : byte/half/word extraction with sign or zero extension.
//   Also flags undefined funct3 codes and misaligned accesses.
// Configuration macro: MEM_MISALIGN_TRAP_EN
//   defined   -> misalign_o flags half accesses with a[0]=1 and word accesses with a!=0
//   undefined -> misalign_o is 0; low address bits are simply ignored
// Ports:
//   funct3_i   : access size/sign code
//   is_store_i : 1 = store, 0 = load
//   addr_lo_i  : effective address bits [1:0]
//   wdata_i    : store data (unshifted)
//   rdata_i    : raw read word from memory
//   wstrb_o    : byte strobes (0 for loads)
//   wdata_o    : lane-replicated store data (0 for loads)
//   rdata_o    : extracted and extended load data
//   legal_o    : funct3 is a defined code for this access direction
//   misalign_o : access is misaligned and must trap
module lsu_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic            is_store_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      wstrb_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            legal_o,
    output logic            misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        half_acc;
    logic        word_acc;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = '0;
        rdata_o = '0;
        legal_o = 1'b0;
        if (is_store_i) begin
            case (funct3_i)
                SB: begin
                    legal_o = 1'b1;
                    wstrb_o = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                SH: begin
                    legal_o = 1'b1;
                    wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                    wdata_o = {2{wdata_i[15:0]}};
                end
                SW: begin
                    legal_o = 1'b1;
                    wstrb_o = 4'b1111;
                    wdata_o = wdata_i;
                end
                default: legal_o = 1'b0;
            endcase
        end else begin
            case (funct3_i)
                LB: begin
                    legal_o = 1'b1;
                    rdata_o = {{24{byte_sel[7]}}, byte_sel};
                end
                LBU: begin
                    legal_o = 1'b1;
                    rdata_o = {24'd0, byte_sel};
                end
                LH: begin
                    legal_o = 1'b1;
                    rdata_o = {{16{half_sel[15]}}, half_sel};
                end
                LHU: begin
                    legal_o = 1'b1;
                    rdata_o = {16'd0, half_sel};
                end
                LW: begin
                    legal_o = 1'b1;
                    rdata_o = rdata_i;
                end
                default: legal_o = 1'b0;
            endcase
        end
    end

    // Load and store codes share size encoding in funct3[1:0].
    assign half_acc = legal_o & (funct3_i[1:0] == 2'b01);
    assign word_acc = legal_o & (funct3_i[1:0] == 2'b10);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_o = (half_acc & addr_lo_i[0]) | (word_acc & (addr_lo_i != 2'b00));
`else
    logic unused_size;
    assign unused_size = half_acc ^ word_acc;
    assign misalign_o  = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage RISC-V pipeline.
//   Issues loads/stores on a valid/ready data bus, stalls upstream while an
//   access is outstanding, and registers the M/W pipeline fields.
// Configuration macro: MEM_MISALIGN_TRAP_EN (misaligned half/word accesses
//   trap with a one-cycle misalignW pulse instead of being aligned down).
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   regwriteM..pc4M       : E/M pipeline inputs
//   dmem_valid/we/addr/wdata/wstrb, dmem_ready/rdata : data memory bus
//   stallM                : freeze F/D/E and E/M this cycle
//   regwriteW..misalignW  : M/W pipeline outputs
module mem_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            regwriteM,
    input  logic            memrwM,
    input  logic [1:0]      wbselM,
    input  logic [2:0]      funct3M,
    input  logic [4:0]      rdM,
    input  logic [XLEN-1:0] ALUresM,
    input  logic [XLEN-1:0] data_writeM,
    input  logic [XLEN-1:0] pc4M,
    output logic            dmem_valid,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stallM,
    output logic            regwriteW,
    output logic [1:0]      wbselW,
    output logic [4:0]      rdW,
    output logic [XLEN-1:0] ALUresW,
    output logic [XLEN-1:0] readdataW,
    output logic [XLEN-1:0] pc4W,
    output logic            misalignW
);

    mem_state_e      state_q;
    logic            is_store, is_load, memop, req, done;
    logic            legal, misalign;
    logic [3:0]      strb;
    logic [XLEN-1:0] wdata_lane, rdata_ext;

    logic            regwrite_q, regwrite_d;
    logic [1:0]      wbsel_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] alures_q, readdata_q, readdata_d, pc4_q;
    logic            misalign_q, misalign_d;

    assign is_store = memrwM;
    assign is_load  = !memrwM & regwriteM & (wbselM == WB_MEM);
    assign memop    = is_store | is_load;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3_i   (funct3M),
        .is_store_i (is_store),
        .addr_lo_i  (ALUresM[1:0]),
        .wdata_i    (data_writeM),
        .rdata_i    (dmem_rdata),
        .wstrb_o    (strb),
        .wdata_o    (wdata_lane),
        .rdata_o    (rdata_ext),
        .legal_o    (legal),
        .misalign_o (misalign)
    );

    assign req = memop & legal & !misalign;

    // Gating with rst_n makes reset drop the request at once, even mid-WAIT.
    // In WAIT the E/M inputs are frozen by stallM, so the bus stays stable.
    assign dmem_valid = rst_n & (req | (state_q == S_WAIT));
    assign dmem_we    = dmem_valid & is_store;
    assign dmem_addr  = {ALUresM[XLEN-1:2], 2'b00};
    assign dmem_wdata = wdata_lane;
    assign dmem_wstrb = dmem_we ? strb : 4'b0000;
    assign stallM     = dmem_valid & !dmem_ready;
    assign done       = dmem_valid & dmem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (stallM) state_q <= S_WAIT;
                S_WAIT:  if (dmem_ready) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        regwrite_d = regwriteM & !(memop & (!legal | misalign));
        misalign_d = memop & misalign;
        readdata_d = readdata_q;
        if (is_load & done)
            readdata_d = rdata_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q <= 1'b0;
            wbsel_q    <= 2'b00;
            rd_q       <= 5'd0;
            alures_q   <= '0;
            readdata_q <= '0;
            pc4_q      <= '0;
            misalign_q <= 1'b0;
        end else if (stallM) begin
            // bubble: only the write enable and trap pulse are cleared
            regwrite_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            regwrite_q <= regwrite_d;
            wbsel_q    <= wbselM;
            rd_q       <= rdM;
            alures_q   <= ALUresM;
            readdata_q <= readdata_d;
            pc4_q      <= pc4M;
            misalign_q <= misalign_d;
        end
    end

    assign regwriteW = regwrite_q;
    assign wbselW    = wbsel_q;
    assign rdW       = rd_q;
    assign ALUresW   = alures_q;
    assign readdataW = readdata_q;
    assign pc4W      = pc4_q;
    assign misalignW = misalign_q;

endmodule
